sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock FIFO controller that drives the write and read ports of the team's dual-port RAM.
//  Owns the pointers, the occupancy count, the flags and the read-valid pipeline.
//  The RAM's rdclk is tied to wrclk at the top level, so the whole FIFO runs on one clock.
//  The host sees a push/pop interface; the RAM sees wren/wraddress and rden/rdaddress.
// PARAMETERS
//  DATA_WIDTH   8    word width; must match the RAM
//  ADDR_BIT     9    RAM address width; must match the RAM
//  ADDR_DEPTH   512  entries; 2 <= ADDR_DEPTH <= 2**ADDR_BIT
//  AF_LEVEL     500  almost_full asserts when count >= AF_LEVEL
//  AE_LEVEL     4    almost_empty asserts when count <= AE_LEVEL
// PORTS
//  wrclk         in   1             clock for the controller and the RAM
//  rst_n         in   1             synchronous reset, active low
//  wr_en         in   1             push request
//  wr_data       in   DATA_WIDTH    push data
//  rd_en         in   1             pop request
//  rd_data       out  DATA_WIDTH    pop data; qualified by rd_valid
//  rd_valid      out  1             rd_data valid this cycle
//  full          out  1             count == ADDR_DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AF_LEVEL
//  almost_empty  out  1             count <= AE_LEVEL
//  usedw         out  ADDR_BIT+1    occupancy count
//  err_clr       in   1             clears overflow and underflow
//  overflow      out  1             sticky: push attempted while full
//  underflow     out  1             sticky: pop attempted while empty
//  ram_wren      out  1             to RAM wren
//  ram_wraddress out  ADDR_BIT      to RAM wraddress
//  ram_wrdata    out  DATA_WIDTH    to RAM wrdata
//  ram_rden      out  1             to RAM rden
//  ram_rdaddress out  ADDR_BIT      to RAM rdaddress
//  ram_rddata    in   DATA_WIDTH    from RAM rddata (registered in the RAM)
// BEHAVIOUR
//  Reset (rst_n=0 at a wrclk edge):
//   - wr_ptr=0, rd_ptr=0, count=0
//   - empty=1, almost_empty=1; full=0, almost_full=0
//   - rd_valid=0, overflow=0, underflow=0
//   - Reset mid-operation drops any in-flight pop: rd_valid=0 after that edge.
//  Accept rules (flags are registered; gating uses the pre-edge state):
//   - wa = wr_en & ~full;  ra = rd_en & ~empty
//   - Full with wr_en & rd_en: the pop is accepted, the push is rejected (overflow sets).
//   - Empty with wr_en & rd_en: the push is accepted, the pop is rejected (underflow sets).
//  RAM drive (combinational):
//   - ram_wren=wa, ram_wraddress=wr_ptr, ram_wrdata=wr_data
//   - ram_rden=ra, ram_rdaddress=rd_ptr
//   - No same-address read/write can occur: equal pointers imply full or empty, and the rules above exclude it.
//  Pointers: each advances by 1 on its accept; it wraps from ADDR_DEPTH-1 to 0 (explicit compare, no power-of-2 requirement).
//  Count: count <= count + wa - ra, so wa & ra leaves count unchanged. All flags are registered from the next count.
//  Read latency: 1 cycle. rd_valid=1 in the cycle after ra. rd_data = ram_rddata (passthrough).
//   - rd_data holds its last value while rd_valid=0.
//  Errors:
//   - overflow sets on wr_en & full; underflow sets on rd_en & empty.
//   - err_clr clears both; a set in the same cycle wins over err_clr.
//   - Rejected operations change no pointer or count.
// TESTING
//  - Reset, then idle -> empty=1, usedw=0, rd_valid=0, ram_wren=0, ram_rden=0.
//  - Push 0x01..0x05, then pop 5 times -> rd_valid one cycle after each pop; data 0x01..0x05 in order; empty=1 at end.
//  - Fill 512 entries -> full=1, usedw=512, almost_full from count 500.
//    Then push+pop in the same cycle -> pop accepted, push rejected, overflow=1, usedw=511.
//  - Empty, push+pop in the same cycle -> push accepted, usedw=1, underflow=1, rd_valid=0 next cycle.
//  - ADDR_DEPTH=5: 12 push/pop pairs -> pointers wrap 4->0, data order intact, no address >= 5 on the RAM.
//  - Pop accepted, rst_n=0 on the next edge -> rd_valid=0, usedw=0, errors cleared; err_clr with a set in the same cycle -> flag stays 1.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// sync_fifo_ctrl : single-clock FIFO controller driving a dual-port RAM
// Revision 1.0
// ============================================================================
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BIT   = 9,
   parameter int ADDR_DEPTH = 512,
   parameter int AF_LEVEL   = 500,
   parameter int AE_LEVEL   = 4
) (
   input  logic                  wrclk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_BIT:0]     usedw,
   input  logic                  err_clr,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ram_wren,
   output logic [ADDR_BIT-1:0]   ram_wraddress,
   output logic [DATA_WIDTH-1:0] ram_wrdata,
   output logic                  ram_rden,
   output logic [ADDR_BIT-1:0]   ram_rdaddress,
   input  logic [DATA_WIDTH-1:0] ram_rddata
);

   localparam int                  CNT_W     = ADDR_BIT + 1;
   localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(ADDR_DEPTH - 1);
   localparam logic [ADDR_BIT-1:0] ADDR_ONE  = ADDR_BIT'(1);
   localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(ADDR_DEPTH);
   localparam logic [CNT_W-1:0]    AF_CNT    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0]    AE_CNT    = CNT_W'(AE_LEVEL);

   logic [ADDR_BIT-1:0] r_wr_ptr;
   logic [ADDR_BIT-1:0] r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic                w_wa;
   logic                w_ra;
   logic [ADDR_BIT-1:0] w_wr_ptr_nxt;
   logic [ADDR_BIT-1:0] w_rd_ptr_nxt;
   logic [CNT_W-1:0]    w_count_nxt;

   // Accepts are gated by the registered flags, i.e. the state before this edge.
   assign w_wa = wr_en & ~full;
   assign w_ra = rd_en & ~empty;

   assign ram_wren      = w_wa;
   assign ram_wraddress = r_wr_ptr;
   assign ram_wrdata    = wr_data;
   assign ram_rden      = w_ra;
   assign ram_rdaddress = r_rd_ptr;

   assign rd_data = ram_rddata;
   assign usedw   = r_count;

   // Explicit wrap compare so ADDR_DEPTH need not be a power of two.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      if (w_wa) begin
         w_wr_ptr_nxt = (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + ADDR_ONE;
      end
      if (w_ra) begin
         w_rd_ptr_nxt = (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + ADDR_ONE;
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wa, w_ra})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge wrclk) begin
      if (!rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         rd_valid     <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         r_wr_ptr     <= w_wr_ptr_nxt;
         r_rd_ptr     <= w_rd_ptr_nxt;
         r_count      <= w_count_nxt;
         full         <= (w_count_nxt == DEPTH_CNT);
         empty        <= (w_count_nxt == '0);
         almost_full  <= (w_count_nxt >= AF_CNT);
         almost_empty <= (w_count_nxt <= AE_CNT);
         rd_valid     <= w_ra;
         // A new error event takes priority over a simultaneous clear.
         overflow     <= (wr_en & full)  | (overflow  & ~err_clr);
         underflow    <= (rd_en & empty) | (underflow & ~err_clr);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// Testbench for sync_fifo_ctrl: a 512-deep and a 5-deep instance share stimulus,
// each backed by a RAM model and compared against a queue-based FIFO model.
module tb_sync_fifo_ctrl;

   logic       wrclk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic       rd_en;
   logic       err_clr;
   logic [7:0] wr_data;

   always #5 wrclk = ~wrclk;

   // Instance 0: default geometry
   logic [7:0] rd_data0, ram_wrdata0, ram_rddata0;
   logic       rd_valid0, full0, empty0, af0, ae0, ovf0, unf0, ram_wren0, ram_rden0;
   logic [9:0] usedw0;
   logic [8:0] ram_wraddress0, ram_rdaddress0;

   // Instance 1: 5 entries, non power of two
   logic [7:0] rd_data1, ram_wrdata1, ram_rddata1;
   logic       rd_valid1, full1, empty1, af1, ae1, ovf1, unf1, ram_wren1, ram_rden1;
   logic [3:0] usedw1;
   logic [2:0] ram_wraddress1, ram_rdaddress1;

   sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_BIT(9), .ADDR_DEPTH(512), .AF_LEVEL(500), .AE_LEVEL(4)) dut0 (
      .wrclk(wrclk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .usedw(usedw0), .err_clr(err_clr),
      .overflow(ovf0), .underflow(unf0), .ram_wren(ram_wren0), .ram_wraddress(ram_wraddress0),
      .ram_wrdata(ram_wrdata0), .ram_rden(ram_rden0), .ram_rdaddress(ram_rdaddress0),
      .ram_rddata(ram_rddata0));

   sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_BIT(3), .ADDR_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut1 (
      .wrclk(wrclk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .usedw(usedw1), .err_clr(err_clr),
      .overflow(ovf1), .underflow(unf1), .ram_wren(ram_wren1), .ram_wraddress(ram_wraddress1),
      .ram_wrdata(ram_wrdata1), .ram_rden(ram_rden1), .ram_rdaddress(ram_rdaddress1),
      .ram_rddata(ram_rddata1));

   // Dual-port RAMs with registered read data
   logic [7:0] mem0 [512];
   logic [7:0] mem1 [8];
   logic [7:0] ram_q0 = 8'h00;
   logic [7:0] ram_q1 = 8'h00;
   assign ram_rddata0 = ram_q0;
   assign ram_rddata1 = ram_q1;

   always @(posedge wrclk) begin
      if (ram_wren0) mem0[ram_wraddress0] <= ram_wrdata0;
      if (ram_rden0) ram_q0 <= mem0[ram_rdaddress0];
      if (ram_wren1) mem1[ram_wraddress1] <= ram_wrdata1;
      if (ram_rden1) ram_q1 <= mem1[ram_rdaddress1];
   end

   // Observed values gathered per instance
   logic [31:0] o_wren [2], o_wa [2], o_wd [2], o_rden [2], o_ra [2];
   logic [31:0] o_usedw [2], o_flags [2], o_rd [2];
   assign o_wren[0]  = 32'(ram_wren0);
   assign o_wa[0]    = 32'(ram_wraddress0);
   assign o_wd[0]    = 32'(ram_wrdata0);
   assign o_rden[0]  = 32'(ram_rden0);
   assign o_ra[0]    = 32'(ram_rdaddress0);
   assign o_usedw[0] = 32'(usedw0);
   assign o_flags[0] = 32'({rd_valid0, full0, empty0, af0, ae0, ovf0, unf0});
   assign o_rd[0]    = 32'(rd_data0);
   assign o_wren[1]  = 32'(ram_wren1);
   assign o_wa[1]    = 32'(ram_wraddress1);
   assign o_wd[1]    = 32'(ram_wrdata1);
   assign o_rden[1]  = 32'(ram_rden1);
   assign o_ra[1]    = 32'(ram_rdaddress1);
   assign o_usedw[1] = 32'(usedw1);
   assign o_flags[1] = 32'({rd_valid1, full1, empty1, af1, ae1, ovf1, unf1});
   assign o_rd[1]    = 32'(rd_data1);

   int total = 0;
   int bad   = 0;

   // Reference model: contents as queues, addresses as plain modular counters
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int         wp [2];
   int         rp [2];
   logic       movf [2];
   logic       munf [2];
   logic       mvalid [2];
   logic [7:0] mlast [2];

   function automatic int mdepth(input int k); return (k == 0) ? 512 : 5; endfunction
   function automatic int maf(input int k);    return (k == 0) ? 500 : 4; endfunction
   function automatic int mae(input int k);    return (k == 0) ? 4   : 1; endfunction
   function automatic int qsize(input int k);  return (k == 0) ? q0.size() : q1.size(); endfunction
   function automatic logic [7:0] qfront(input int k); return (k == 0) ? q0[0] : q1[0]; endfunction

   task automatic qpop(input int k);
      logic [7:0] t;
      if (k == 0) t = q0.pop_front(); else t = q1.pop_front();
   endtask

   task automatic qpush(input int k, input logic [7:0] d);
      if (k == 0) q0.push_back(d); else q1.push_back(d);
   endtask

   task automatic qclr(input int k);
      if (k == 0) q0.delete(); else q1.delete();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check RAM drive, clock, update model, check outputs.
   task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                      input logic clr, input logic rst);
      logic wa [2];
      logic rr [2];
      int   n;
      wr_en = w; wr_data = d; rd_en = r; err_clr = clr; rst_n = !rst;
      #1;
      for (int k = 0; k < 2; k++) begin
         n     = qsize(k);
         wa[k] = w && (n != mdepth(k));
         rr[k] = r && (n != 0);
         chk($sformatf("ram_wren[%0d]", k), o_wren[k], 32'(wa[k]));
         if (wa[k]) begin
            chk($sformatf("ram_wraddress[%0d]", k), o_wa[k], 32'(wp[k]));
            chk($sformatf("ram_wrdata[%0d]", k), o_wd[k], 32'(d));
         end
         chk($sformatf("ram_rden[%0d]", k), o_rden[k], 32'(rr[k]));
         if (rr[k]) chk($sformatf("ram_rdaddress[%0d]", k), o_ra[k], 32'(rp[k]));
      end
      @(posedge wrclk);
      for (int k = 0; k < 2; k++) begin
         n = qsize(k);
         if (rr[k]) mlast[k] = qfront(k);
         if (rst) begin
            qclr(k);
            wp[k] = 0; rp[k] = 0;
            movf[k] = 1'b0; munf[k] = 1'b0; mvalid[k] = 1'b0;
         end else begin
            movf[k]   = (w && n == mdepth(k)) || (movf[k] && !clr);
            munf[k]   = (r && n == 0) || (munf[k] && !clr);
            mvalid[k] = rr[k];
            if (rr[k]) begin qpop(k); rp[k] = (rp[k] + 1) % mdepth(k); end
            if (wa[k]) begin qpush(k, d); wp[k] = (wp[k] + 1) % mdepth(k); end
         end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
         n = qsize(k);
         chk($sformatf("usedw[%0d]", k), o_usedw[k], 32'(n));
         chk($sformatf("flags{vld,f,e,af,ae,ovf,unf}[%0d]", k), o_flags[k],
             32'({mvalid[k], n == mdepth(k), n == 0, n >= maf(k), n <= mae(k), movf[k], munf[k]}));
         chk($sformatf("rd_data[%0d]", k), o_rd[k], 32'(mlast[k]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         wp[k] = 0; rp[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0;
         mvalid[k] = 1'b0; mlast[k] = 8'h00;
      end
      wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00; rst_n = 1'b0;

      // Reset and idle
      cyc(0, 8'h00, 0, 0, 1);
      cyc(0, 8'h00, 0, 0, 1);
      repeat (2) cyc(0, 8'h00, 0, 0, 0);

      // Ordered push of 0x01..0x05 then five pops
      for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);
      chk("end_of_pops_empty", 32'(empty0), 32'd1);

      // Fill the deep instance, then simultaneous push+pop while full
      for (int i = 0; i < 512; i++) cyc(1, 8'($urandom), 0, 0, 0);
      chk("fill_usedw", 32'(usedw0), 32'd512);
      cyc(1, 8'($urandom), 1, 0, 0);
      chk("full_pushpop_usedw", 32'(usedw0), 32'd511);
      chk("full_pushpop_overflow", 32'(ovf0), 32'd1);
      cyc(0, 8'h00, 0, 1, 0);

      // Drain, then simultaneous push+pop while empty
      for (int i = 0; i < 511; i++) cyc(0, 8'h00, 1, 0, 0);
      cyc(1, 8'hA5, 1, 0, 0);
      chk("empty_pushpop_usedw", 32'(usedw0), 32'd1);
      chk("empty_pushpop_underflow", 32'(unf0), 32'd1);
      cyc(0, 8'h00, 1, 1, 0);
      cyc(0, 8'h00, 0, 0, 0);

      // Push/pop pairs walk the 5-entry pointers around the wrap
      for (int i = 0; i < 12; i++) begin
         cyc(1, 8'($urandom), 0, 0, 0);
         cyc(0, 8'h00, 1, 0, 0);
      end

      // Random traffic, filling phase then draining phase
      for (int i = 0; i < 700; i++) begin
         int pw;
         int pr;
         pw = (i < 350) ? 70 : 30;
         pr = (i < 350) ? 40 : 70;
         cyc($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
             $urandom_range(99) < 5, 0);
      end

      // Reset cancels an in-flight pop and clears the errors
      cyc(0, 8'h00, 0, 0, 1);
      cyc(0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 1, 0, 1);
      chk("reset_rd_valid", 32'(rd_valid0), 32'd0);
      chk("reset_underflow", 32'(unf0), 32'd0);

      // Error set in the same cycle as err_clr stays set
      cyc(0, 8'h00, 1, 1, 0);
      chk("clr_vs_set_underflow", 32'(unf0), 32'd1);
      cyc(0, 8'h00, 0, 1, 0);
      cyc(0, 8'h00, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
